// File: rtl/nibble_sum_accum_pkg.sv
// Shared types and helpers for the nibble sum accumulator.
// Holds the FSM state encoding, the default sample width and a constant clog2.
package nibble_pkg;

   typedef enum logic {ACCUM = 1'b0, FULL = 1'b1} state_t;

   localparam int SUM_W_DEF = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/nibble_sum_accum_if.sv
// Sample-in / block-result-out handshake bundle.
// The master side drives samples and consumes results; the slave side is the accumulator.
interface nibble_sum_accum_if #(
   parameter int SUM_W = 4,
   parameter int ACC_W = 12
);
   logic             in_valid;
   logic             in_ready;
   logic [SUM_W-1:0] in_sum;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_total;
   logic [SUM_W-1:0] out_max;
   logic             out_ovf;

   modport master (
      output in_valid, in_sum, out_ready,
      input  in_ready, out_valid, out_total, out_max, out_ovf
   );

   modport slave (
      input  in_valid, in_sum, out_ready,
      output in_ready, out_valid, out_total, out_max, out_ovf
   );
endinterface

// File: rtl/nibble_sum_accum_sat_accum.sv
// Combinational next-value logic for one accepted sample:
// saturating running total, running maximum and sticky overflow flag.
module sat_accum #(
   parameter int SUM_W = 4,
   parameter int ACC_W = 12
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [SUM_W-1:0] max_in,
   input  logic             ovf,
   input  logic [SUM_W-1:0] sample,
   output logic [ACC_W-1:0] acc_nxt,
   output logic [SUM_W-1:0] max_nxt,
   output logic             ovf_nxt
);
   logic [ACC_W:0] sum;
   logic           carry;

   // One extra bit catches the carry; once saturated the carry keeps the total pinned.
   assign sum     = {1'b0, acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, sample};
   assign carry   = sum[ACC_W];
   assign acc_nxt = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
   assign max_nxt = (sample > max_in) ? sample : max_in;
   assign ovf_nxt = ovf | carry;
endmodule

// File: rtl/nibble_sum_accum.sv
// Accumulates COUNT unsigned samples into a saturated block total with max/overflow,
// and holds each block result on a registered valid/ready port until consumed.
module nibble_sum_accum
   import nibble_pkg::*;
#(
   parameter int SUM_W = SUM_W_DEF,
   parameter int COUNT = 8,
   parameter int ACC_W = 12
) (
   input  logic               clk,
   input  logic               reset,
   nibble_sum_accum_if.slave  bus
);
   localparam int             CNT_W = clog2(COUNT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt;
   logic [ACC_W-1:0] acc, acc_nxt;
   logic [SUM_W-1:0] max_q, max_nxt;
   logic             ovf, ovf_nxt;
   logic             take, blk_end;
   logic [ACC_W-1:0] total_q;
   logic [SUM_W-1:0] omax_q;
   logic             oovf_q;

   sat_accum #(.SUM_W(SUM_W), .ACC_W(ACC_W)) u_sat (
      .acc     (acc),
      .max_in  (max_q),
      .ovf     (ovf),
      .sample  (bus.in_sum),
      .acc_nxt (acc_nxt),
      .max_nxt (max_nxt),
      .ovf_nxt (ovf_nxt)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ACCUM;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      bus.in_ready = 1'b0;
      blk_end     = 1'b0;
      case (state_q)
         ACCUM: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid && cnt == LAST) begin
               blk_end = 1'b1;
               state_d = FULL;
            end
         end
         FULL: begin
            bus.in_ready = bus.out_ready;
            if (bus.out_ready) state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   assign take = bus.in_valid & bus.in_ready;

   // Accumulators are cleared on block end, so a sample taken while FULL
   // drains naturally becomes the first sample of the next block.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         acc     <= '0;
         max_q   <= '0;
         ovf     <= 1'b0;
         total_q <= '0;
         omax_q  <= '0;
         oovf_q  <= 1'b0;
      end else if (take) begin
         if (blk_end) begin
            total_q <= acc_nxt;
            omax_q  <= max_nxt;
            oovf_q  <= ovf_nxt;
            cnt     <= '0;
            acc     <= '0;
            max_q   <= '0;
            ovf     <= 1'b0;
         end else begin
            cnt     <= cnt + CNT_W'(1);
            acc     <= acc_nxt;
            max_q   <= max_nxt;
            ovf     <= ovf_nxt;
         end
      end
   end

   assign bus.out_valid = (state_q == FULL);
   assign bus.out_total = total_q;
   assign bus.out_max   = omax_q;
   assign bus.out_ovf   = oovf_q;
endmodule

// File: tb/tb_nibble_sum_accum.sv
// Randomized and directed check of nibble_sum_accum against a block-level model.
module tb_nibble_sum_accum;
   localparam int COUNT = 8;
   localparam int ACC_W = 12;
   localparam int SATV  = (1 << ACC_W) - 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   nibble_sum_accum_if #(.SUM_W(4), .ACC_W(ACC_W)) bus ();
   nibble_sum_accum_if #(.SUM_W(4), .ACC_W(5))     bus2 ();

   nibble_sum_accum #(.SUM_W(4), .COUNT(COUNT), .ACC_W(ACC_W)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave));
   nibble_sum_accum #(.SUM_W(4), .COUNT(4), .ACC_W(5)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2.slave));

   int vecs = 0;
   int errs = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Block-level model: collect samples; at COUNT, total = min(sum, 2**ACC_W-1).
   bit mon = 0;
   bit m_valid = 0;
   int m_total = 0, m_max = 0, m_ovf = 0, res_cnt = 0;
   int blk[$];

   always @(negedge clk) begin
      bit rdy;
      int s, mx;
      rdy = !m_valid || bus.out_ready;
      if (mon) begin
         chk("in_ready",  bus.in_ready,  rdy);
         chk("out_valid", bus.out_valid, m_valid);
         chk("out_total", bus.out_total, m_total);
         chk("out_max",   bus.out_max,   m_max);
         chk("out_ovf",   bus.out_ovf,   m_ovf);
      end
      if (reset) begin
         m_valid = 0; m_total = 0; m_max = 0; m_ovf = 0;
         blk.delete();
      end else begin
         if (m_valid && bus.out_ready) m_valid = 0;
         if (bus.in_valid && rdy) begin
            blk.push_back(int'(bus.in_sum));
            if (blk.size() == COUNT) begin
               s = 0; mx = 0;
               foreach (blk[i]) begin
                  s += blk[i];
                  if (blk[i] > mx) mx = blk[i];
               end
               m_total = (s > SATV) ? SATV : s;
               m_ovf   = (s > SATV) ? 1 : 0;
               m_max   = mx;
               m_valid = 1;
               res_cnt++;
               blk.delete();
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic v, input logic [3:0] s, input logic r);
      bus.in_valid  = v;
      bus.in_sum    = s;
      bus.out_ready = r;
      tick();
   endtask

   initial begin
      int base;
      int n;
      bus.in_valid = 1'b1; bus.in_sum = 4'd5; bus.out_ready = 1'b1;
      bus2.in_valid = 1'b0; bus2.in_sum = 4'd0; bus2.out_ready = 1'b1;

      // Reset with in_valid held high
      reset = 1'b1;
      repeat (2) tick();
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst in_ready",  bus.in_ready,  1);
      chk("rst out_total", bus.out_total, 0);
      chk("rst out_max",   bus.out_max,   0);
      chk("rst out_ovf",   bus.out_ovf,   0);
      bus.in_valid = 1'b0;
      reset = 1'b0;
      mon = 1;
      tick();

      // Basic block 1..8
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 4'(i), 1'b1);
         if (i == 7) chk("basic early valid", bus.out_valid, 0);
      end
      chk("basic valid", bus.out_valid, 1);
      chk("basic total", bus.out_total, 36);
      chk("basic max",   bus.out_max,   8);
      chk("basic ovf",   bus.out_ovf,   0);
      cyc(1'b0, 4'd0, 1'b1);
      chk("basic drained", bus.out_valid, 0);

      // Backpressure: finish a block while out_ready=0, then stall
      for (int i = 0; i < 8; i++) cyc(1'b1, 4'd2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 4'd9, 1'b0);
         chk("stall in_ready", bus.in_ready, 0);
         chk("stall total",    bus.out_total, 16);
      end
      cyc(1'b1, 4'd3, 1'b1);
      chk("bp released", bus.out_valid, 0);
      for (int i = 0; i < 7; i++) cyc(1'b1, 4'd1, 1'b1);
      chk("bp next total", bus.out_total, 10);
      chk("bp next max",   bus.out_max,   3);
      cyc(1'b0, 4'd0, 1'b1);

      // Saturation on the small instance
      bus2.in_valid = 1'b1; bus2.in_sum = 4'd15;
      repeat (4) tick();
      chk("sat valid", bus2.out_valid, 1);
      chk("sat total", bus2.out_total, 31);
      chk("sat ovf",   bus2.out_ovf,   1);
      chk("sat max",   bus2.out_max,   15);
      for (int i = 1; i <= 4; i++) begin
         bus2.in_sum = 4'(i);
         tick();
      end
      chk("sat2 total", bus2.out_total, 10);
      chk("sat2 ovf",   bus2.out_ovf,   0);
      chk("sat2 max",   bus2.out_max,   4);
      bus2.in_valid = 1'b0;
      tick();

      // Random gaps, out_ready high, three blocks
      base = res_cnt; n = 0;
      while (res_cnt < base + 3 && n < 3000) begin
         cyc(1'(($urandom % 2)), 4'($urandom), 1'b1);
         n++;
      end
      chk("rand3 blocks done", (res_cnt >= base + 3), 1);

      // Random gaps and random backpressure
      base = res_cnt; n = 0;
      while (res_cnt < base + 4 && n < 5000) begin
         cyc(1'(($urandom % 2)), 4'($urandom), 1'(($urandom % 3) != 0));
         n++;
      end
      chk("randbp blocks done", (res_cnt >= base + 4), 1);
      cyc(1'b0, 4'd0, 1'b1);

      // Mid-block reset
      for (int i = 0; i < 5; i++) cyc(1'b1, 4'd9, 1'b1);
      reset = 1'b1;
      cyc(1'b0, 4'd0, 1'b1);
      chk("midrst valid", bus.out_valid, 0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) cyc(1'b1, 4'd2, 1'b1);
      chk("midrst total", bus.out_total, 16);
      chk("midrst max",   bus.out_max,   2);
      chk("midrst ovf",   bus.out_ovf,   0);
      cyc(1'b0, 4'd0, 1'b1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
